// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store memory access FSM with byte-lane steering and load extension
// Optional MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of issuing them aligned.
module mem_access_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  MEM_WRITE,
    input  logic [3:0]  MEM_READ,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic [3:0]  MEM_BYTE_EN,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    size_t       size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lane_q, lane_d;

    logic        req, trap, accept, uns;
    size_t       size;
    logic [1:0]  lane;
    logic [15:0] sel_half;
    logic [7:0]  sel_byte;

    // Decode the incoming request; a store always takes priority over a load.
    always_comb begin
        req  = MEM_WRITE[2] | MEM_READ[3];
        uns  = 1'b0;
        size = SZ_W;
        if (MEM_WRITE[2]) begin
            case (MEM_WRITE[1:0])
                2'b00:   size = SZ_B;
                2'b01:   size = SZ_H;
                default: size = SZ_W;
            endcase
        end else begin
            case (MEM_READ[2:0])
                3'b000:  size = SZ_B;
                3'b001:  size = SZ_H;
                3'b100:  begin size = SZ_B; uns = 1'b1; end
                3'b101:  begin size = SZ_H; uns = 1'b1; end
                default: size = SZ_W;
            endcase
        end
        case (size)
            SZ_B:    lane = ADDRESS[1:0];
            SZ_H:    lane = {ADDRESS[1], 1'b0};
            default: lane = 2'b00;
        endcase
`ifdef MISALIGN_TRAP_EN
        trap = req & (((size == SZ_H) & ADDRESS[0]) | ((size == SZ_W) & (ADDRESS[1:0] != 2'b00)));
`else
        trap = 1'b0;
`endif
        accept = req & ~trap;
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        size_d   = size_q;
        uns_d    = uns_q;
        lane_d   = lane_q;
        rdata_d  = rdata_q;
        sel_half = lane_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
        sel_byte = lane_q[0] ? sel_half[15:8] : sel_half[7:0];
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                    we_d    = MEM_WRITE[2];
                    addr_d  = {ADDRESS[31:2], 2'b00};
                    size_d  = size;
                    uns_d   = uns;
                    lane_d  = lane;
                    be_d    = 4'b1111;
                    wdata_d = WRITE_DATA;
                    if (MEM_WRITE[2]) begin
                        case (size)
                            SZ_B: begin
                                be_d    = 4'b0001 << lane;
                                wdata_d = {4{WRITE_DATA[7:0]}};
                            end
                            SZ_H: begin
                                be_d    = 4'b0011 << lane;
                                wdata_d = {2{WRITE_DATA[15:0]}};
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ACCESS: begin
                if (MEM_ACK) begin
                    state_d = DONE;
                    if (!we_q) begin
                        case (size_q)
                            SZ_B:    rdata_d = {{24{sel_byte[7] & ~uns_q}}, sel_byte};
                            SZ_H:    rdata_d = {{16{sel_half[15] & ~uns_q}}, sel_half};
                            default: rdata_d = MEM_RDATA;
                        endcase
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            lane_q  <= 2'b00;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lane_q  <= lane_d;
            rdata_q <= rdata_d;
        end
    end

    assign BUSYWAIT    = RESET & (((state_q == IDLE) & accept) | (state_q == ACCESS));
    assign MISALIGNED  = RESET & (state_q == IDLE) & trap;
    assign MEM_REQ     = (state_q == ACCESS);
    assign MEM_WE      = we_q;
    assign MEM_ADDR    = addr_q;
    assign MEM_WDATA   = wdata_q;
    assign MEM_BYTE_EN = be_q;
    assign READ_DATA   = rdata_q;
endmodule
